cjb_alu_status_stage_v: RTL and testbench

CJB_ALU_STATUS_STAGE_V -- requirements
Module: cjb_alu_status_stage_v

---
 rtl/cjb_alu_status_stage_v_pkg.sv | 33 +++
 rtl/cjb_cond_eval_v.sv | 25 ++
 rtl/cjb_alu_status_stage_v.sv | 91 +++++++++
 tb/tb_cjb_alu_status_stage_v.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cjb_alu_status_stage_v_pkg.sv
// Shared cjb definitions: fixed widths, CNVZ bit positions, condition-select encodings
// and the masked flag-merge helper used by the status register.
package cjb_alu_status_stage_v_pkg;

    localparam int DATA_W = 8;
    localparam int FLAG_W = 4;

    // Status/flag vectors are ordered {C,N,V,Z}
    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'b000,
        COND_C      = 3'b001,
        COND_N      = 3'b010,
        COND_V      = 3'b011,
        COND_Z      = 3'b100,
        COND_NOT_Z  = 3'b101,
        COND_NOT_C  = 3'b110,
        COND_N_XOR_V = 3'b111
    } cond_sel_e;

    function automatic logic [FLAG_W-1:0] merge_flags(
        input logic [FLAG_W-1:0] cur,
        input logic [FLAG_W-1:0] upd,
        input logic [FLAG_W-1:0] we
    );
        return (cur & ~we) | (upd & we);
    endfunction

endpackage

// File: rtl/cjb_cond_eval_v.sv
// Branch condition evaluation on the architectural status flags; purely combinational.
module cjb_cond_eval_v
    import cjb_alu_status_stage_v_pkg::*;
(
    input  logic [FLAG_W-1:0] Status_CNVZ,
    input  logic [2:0]        Cond_Sel,
    output logic              Cond_True
);

    always_comb begin
        Cond_True = 1'b0;
        case (cond_sel_e'(Cond_Sel))
            COND_ALWAYS:  Cond_True = 1'b1;
            COND_C:       Cond_True = Status_CNVZ[FLAG_C];
            COND_N:       Cond_True = Status_CNVZ[FLAG_N];
            COND_V:       Cond_True = Status_CNVZ[FLAG_V];
            COND_Z:       Cond_True = Status_CNVZ[FLAG_Z];
            COND_NOT_Z:   Cond_True = ~Status_CNVZ[FLAG_Z];
            COND_NOT_C:   Cond_True = ~Status_CNVZ[FLAG_C];
            COND_N_XOR_V: Cond_True = Status_CNVZ[FLAG_N] ^ Status_CNVZ[FLAG_V];
            default:      Cond_True = 1'b0;
        endcase
    end

endmodule

// File: rtl/cjb_alu_status_stage_v.sv
// ALU result stage: 2-entry result FIFO plus CNVZ status register updated on push.
// Define CJB_SR_LOAD_EN to add a direct status-register load port (SR_Load/SR_Data).
module cjb_alu_status_stage_v
    import cjb_alu_status_stage_v_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [DATA_W-1:0] Arith_Result,
    input  logic [FLAG_W-1:0] Arith_CNVZ,
    input  logic [FLAG_W-1:0] Flag_WE,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Out_Result,
    output logic [FLAG_W-1:0] Status_CNVZ,
    input  logic [2:0]        Cond_Sel,
`ifdef CJB_SR_LOAD_EN
    input  logic              SR_Load,
    input  logic [FLAG_W-1:0] SR_Data,
`endif
    output logic              Cond_True
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [1:0]        count_next;
    logic              in_ready_q;
    logic              push;
    logic              pop;

    assign push = In_Valid & in_ready_q;
    assign pop  = Out_Valid & Out_Ready;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            count      <= count_next;
            in_ready_q <= (count_next != 2'd2);
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
        end
    end

    // Storage needs no reset; occupancy is tracked solely by count
    always_ff @(posedge Clock) begin
        if (!Reset && push) mem[wr_ptr] <= Arith_Result;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Status_CNVZ <= '0;
        end else begin
`ifdef CJB_SR_LOAD_EN
            if (SR_Load)
                Status_CNVZ <= SR_Data;
            else if (push)
                Status_CNVZ <= merge_flags(Status_CNVZ, Arith_CNVZ, Flag_WE);
`else
            if (push)
                Status_CNVZ <= merge_flags(Status_CNVZ, Arith_CNVZ, Flag_WE);
`endif
        end
    end

    assign In_Ready   = in_ready_q;
    assign Out_Valid  = (count != 2'd0);
    assign Out_Result = Out_Valid ? mem[rd_ptr] : '0;

    cjb_cond_eval_v u_cond_eval (
        .Status_CNVZ (Status_CNVZ),
        .Cond_Sel    (Cond_Sel),
        .Cond_True   (Cond_True)
    );

endmodule

// File: tb/tb_cjb_alu_status_stage_v.sv
// Directed bench for cjb_alu_status_stage_v; expected values are hand-computed.
module tb_cjb_alu_status_stage_v;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       In_Valid;
    logic       In_Ready;
    logic [7:0] Arith_Result;
    logic [3:0] Arith_CNVZ;
    logic [3:0] Flag_WE;
    logic       Out_Valid;
    logic       Out_Ready;
    logic [7:0] Out_Result;
    logic [3:0] Status_CNVZ;
    logic [2:0] Cond_Sel;
    logic       Cond_True;
`ifdef CJB_SR_LOAD_EN
    logic       SR_Load;
    logic [3:0] SR_Data;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 Clock = ~Clock;

    cjb_alu_status_stage_v dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .In_Valid     (In_Valid),
        .In_Ready     (In_Ready),
        .Arith_Result (Arith_Result),
        .Arith_CNVZ   (Arith_CNVZ),
        .Flag_WE      (Flag_WE),
        .Out_Valid    (Out_Valid),
        .Out_Ready    (Out_Ready),
        .Out_Result   (Out_Result),
        .Status_CNVZ  (Status_CNVZ),
        .Cond_Sel     (Cond_Sel),
`ifdef CJB_SR_LOAD_EN
        .SR_Load      (SR_Load),
        .SR_Data      (SR_Data),
`endif
        .Cond_True    (Cond_True)
    );

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive_push(input logic v, input logic [7:0] d, input logic [3:0] f, input logic [3:0] we);
        In_Valid     = v;
        Arith_Result = d;
        Arith_CNVZ   = f;
        Flag_WE      = we;
    endtask

    task automatic test_reset();
        logic [7:0] exp_ct;
        exp_ct = 8'b0110_0001;
        Reset = 1'b1;
        drive_push(1'b0, 8'h00, 4'h0, 4'h0);
        Out_Ready = 1'b0;
        Cond_Sel  = 3'b000;
        tick();
        tick();
        Reset = 1'b0;
        vec_cnt++; if (Out_Valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid got %b exp 0", Out_Valid); end
        vec_cnt++; if (In_Ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready got %b exp 1", In_Ready); end
        vec_cnt++; if (Out_Result !== 8'h00) begin err_cnt++; $display("FAIL reset_out_result got %h exp 00", Out_Result); end
        vec_cnt++; if (Status_CNVZ !== 4'b0000) begin err_cnt++; $display("FAIL reset_status got %b exp 0000", Status_CNVZ); end
        for (int s = 0; s < 8; s++) begin
            Cond_Sel = 3'(s);
            #1;
            vec_cnt++;
            if (Cond_True !== exp_ct[s]) begin
                err_cnt++; $display("FAIL reset_cond sel=%0d got %b exp %b", s, Cond_True, exp_ct[s]);
            end
        end
    endtask

    task automatic test_push_basic();
        drive_push(1'b1, 8'h5A, 4'b1001, 4'b1111);
        Out_Ready = 1'b0;
        tick();
        drive_push(1'b0, 8'h00, 4'b0000, 4'b0000);
        Cond_Sel = 3'b001;
        #1;
        vec_cnt++; if (Out_Valid !== 1'b1) begin err_cnt++; $display("FAIL basic_out_valid got %b exp 1", Out_Valid); end
        vec_cnt++; if (Out_Result !== 8'h5A) begin err_cnt++; $display("FAIL basic_out_result got %h exp 5a", Out_Result); end
        vec_cnt++; if (Status_CNVZ !== 4'b1001) begin err_cnt++; $display("FAIL basic_status got %b exp 1001", Status_CNVZ); end
        vec_cnt++; if (Cond_True !== 1'b1) begin err_cnt++; $display("FAIL basic_cond_c got %b exp 1", Cond_True); end
        Cond_Sel = 3'b111;
        #1;
        vec_cnt++; if (Cond_True !== 1'b0) begin err_cnt++; $display("FAIL basic_cond_nxv got %b exp 0", Cond_True); end
        Out_Ready = 1'b1;
        tick();
        Out_Ready = 1'b0;
        vec_cnt++; if (Out_Valid !== 1'b0) begin err_cnt++; $display("FAIL basic_drain_valid got %b exp 0", Out_Valid); end
        vec_cnt++; if (Out_Result !== 8'h00) begin err_cnt++; $display("FAIL basic_drain_result got %h exp 00", Out_Result); end
        vec_cnt++; if (Status_CNVZ !== 4'b1001) begin err_cnt++; $display("FAIL basic_status_hold got %b exp 1001", Status_CNVZ); end
    endtask

    task automatic test_full();
        Out_Ready = 1'b0;
        drive_push(1'b1, 8'h01, 4'b0000, 4'b0000);
        tick();
        vec_cnt++; if (In_Ready !== 1'b1) begin err_cnt++; $display("FAIL full_ready_one got %b exp 1", In_Ready); end
        drive_push(1'b1, 8'h02, 4'b0000, 4'b0000);
        tick();
        vec_cnt++; if (In_Ready !== 1'b0) begin err_cnt++; $display("FAIL full_ready_two got %b exp 0", In_Ready); end
        drive_push(1'b1, 8'h03, 4'b0110, 4'b1111);
        tick();
        drive_push(1'b0, 8'h00, 4'b0000, 4'b0000);
        vec_cnt++; if (In_Ready !== 1'b0) begin err_cnt++; $display("FAIL full_ready_hold got %b exp 0", In_Ready); end
        vec_cnt++; if (Out_Result !== 8'h01) begin err_cnt++; $display("FAIL full_head0 got %h exp 01", Out_Result); end
        vec_cnt++; if (Status_CNVZ !== 4'b1001) begin err_cnt++; $display("FAIL full_status_ignored got %b exp 1001", Status_CNVZ); end
        Out_Ready = 1'b1;
        tick();
        vec_cnt++; if (Out_Result !== 8'h02) begin err_cnt++; $display("FAIL full_head1 got %h exp 02", Out_Result); end
        vec_cnt++; if (In_Ready !== 1'b1) begin err_cnt++; $display("FAIL full_ready_after_pop got %b exp 1", In_Ready); end
        tick();
        vec_cnt++; if (Out_Valid !== 1'b0) begin err_cnt++; $display("FAIL full_empty_valid got %b exp 0", Out_Valid); end
        vec_cnt++; if (Out_Result !== 8'h00) begin err_cnt++; $display("FAIL full_empty_result got %h exp 00", Out_Result); end
        tick();
        tick();
        Out_Ready = 1'b0;
        vec_cnt++; if (Out_Valid !== 1'b0) begin err_cnt++; $display("FAIL underflow_valid got %b exp 0", Out_Valid); end
        drive_push(1'b1, 8'h44, 4'b0000, 4'b0000);
        tick();
        drive_push(1'b0, 8'h00, 4'b0000, 4'b0000);
        vec_cnt++; if (Out_Result !== 8'h44) begin err_cnt++; $display("FAIL underflow_next_push got %h exp 44", Out_Result); end
        vec_cnt++; if (In_Ready !== 1'b1) begin err_cnt++; $display("FAIL underflow_ready got %b exp 1", In_Ready); end
        Out_Ready = 1'b1;
        tick();
        Out_Ready = 1'b0;
        vec_cnt++; if (Out_Valid !== 1'b0) begin err_cnt++; $display("FAIL underflow_drain got %b exp 0", Out_Valid); end
    endtask

    task automatic test_flag_mask();
        Out_Ready = 1'b1;
        drive_push(1'b1, 8'h10, 4'b1111, 4'b1111);
        tick();
        vec_cnt++; if (Status_CNVZ !== 4'b1111) begin err_cnt++; $display("FAIL mask_all_set got %b exp 1111", Status_CNVZ); end
        drive_push(1'b1, 8'h20, 4'b0000, 4'b0001);
        tick();
        drive_push(1'b0, 8'h00, 4'b0000, 4'b0000);
        Cond_Sel = 3'b101;
        #1;
        vec_cnt++; if (Status_CNVZ !== 4'b1110) begin err_cnt++; $display("FAIL mask_z_only got %b exp 1110", Status_CNVZ); end
        vec_cnt++; if (Cond_True !== 1'b1) begin err_cnt++; $display("FAIL mask_cond_nz got %b exp 1", Cond_True); end
        vec_cnt++; if (Out_Result !== 8'h20) begin err_cnt++; $display("FAIL mask_head got %h exp 20", Out_Result); end
        Cond_Sel = 3'b100;
        #1;
        vec_cnt++; if (Cond_True !== 1'b0) begin err_cnt++; $display("FAIL mask_cond_z got %b exp 0", Cond_True); end
        drive_push(1'b0, 8'h00, 4'b0000, 4'b1111);
        tick();
        Out_Ready = 1'b0;
        vec_cnt++; if (Status_CNVZ !== 4'b1110) begin err_cnt++; $display("FAIL mask_no_push_hold got %b exp 1110", Status_CNVZ); end
        vec_cnt++; if (Out_Valid !== 1'b0) begin err_cnt++; $display("FAIL mask_drain got %b exp 0", Out_Valid); end
        drive_push(1'b1, 8'h30, 4'b0001, 4'b0110);
        tick();
        drive_push(1'b0, 8'h00, 4'b0000, 4'b0000);
        vec_cnt++; if (Status_CNVZ !== 4'b1000) begin err_cnt++; $display("FAIL mask_nv_clear got %b exp 1000", Status_CNVZ); end
        Out_Ready = 1'b1;
        tick();
        Out_Ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        Out_Ready = 1'b0;
        drive_push(1'b1, 8'hAA, 4'b0000, 4'b0000);
        tick();
        drive_push(1'b1, 8'hC3, 4'b0000, 4'b0000);
        Out_Ready = 1'b1;
        tick();
        drive_push(1'b0, 8'h00, 4'b0000, 4'b0000);
        Out_Ready = 1'b0;
        vec_cnt++; if (Out_Valid !== 1'b1) begin err_cnt++; $display("FAIL b2b_valid got %b exp 1", Out_Valid); end
        vec_cnt++; if (Out_Result !== 8'hC3) begin err_cnt++; $display("FAIL b2b_head got %h exp c3", Out_Result); end
        vec_cnt++; if (In_Ready !== 1'b1) begin err_cnt++; $display("FAIL b2b_ready got %b exp 1", In_Ready); end
        tick();
        vec_cnt++; if (Out_Result !== 8'hC3) begin err_cnt++; $display("FAIL b2b_hold got %h exp c3", Out_Result); end
        Out_Ready = 1'b1;
        tick();
        Out_Ready = 1'b0;
        vec_cnt++; if (Out_Valid !== 1'b0) begin err_cnt++; $display("FAIL b2b_count_one got %b exp 0", Out_Valid); end
    endtask

`ifdef CJB_SR_LOAD_EN
    task automatic test_sr_load();
        Out_Ready = 1'b0;
        SR_Load   = 1'b1;
        SR_Data   = 4'b0110;
        drive_push(1'b1, 8'hD4, 4'b1001, 4'b1111);
        tick();
        SR_Load = 1'b0;
        drive_push(1'b0, 8'h00, 4'b0000, 4'b0000);
        Cond_Sel = 3'b111;
        #1;
        vec_cnt++; if (Status_CNVZ !== 4'b0110) begin err_cnt++; $display("FAIL sr_status got %b exp 0110", Status_CNVZ); end
        vec_cnt++; if (Out_Result !== 8'hD4) begin err_cnt++; $display("FAIL sr_enqueued got %h exp d4", Out_Result); end
        vec_cnt++; if (Cond_True !== 1'b0) begin err_cnt++; $display("FAIL sr_cond_nxv got %b exp 0", Cond_True); end
        Cond_Sel = 3'b010;
        #1;
        vec_cnt++; if (Cond_True !== 1'b1) begin err_cnt++; $display("FAIL sr_cond_n got %b exp 1", Cond_True); end
        Out_Ready = 1'b1;
        tick();
        Out_Ready = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        Out_Ready = 1'b0;
        drive_push(1'b1, 8'h11, 4'b0000, 4'b0000);
        tick();
        drive_push(1'b1, 8'h22, 4'b1111, 4'b1111);
        tick();
        vec_cnt++; if (In_Ready !== 1'b0) begin err_cnt++; $display("FAIL rstmid_full got %b exp 0", In_Ready); end
        Reset = 1'b1;
        drive_push(1'b1, 8'h33, 4'b1111, 4'b1111);
        tick();
        Reset = 1'b0;
        drive_push(1'b0, 8'h00, 4'b0000, 4'b0000);
        vec_cnt++; if (Out_Valid !== 1'b0) begin err_cnt++; $display("FAIL rstmid_valid got %b exp 0", Out_Valid); end
        vec_cnt++; if (In_Ready !== 1'b1) begin err_cnt++; $display("FAIL rstmid_ready got %b exp 1", In_Ready); end
        vec_cnt++; if (Status_CNVZ !== 4'b0000) begin err_cnt++; $display("FAIL rstmid_status got %b exp 0000", Status_CNVZ); end
        vec_cnt++; if (Out_Result !== 8'h00) begin err_cnt++; $display("FAIL rstmid_result got %h exp 00", Out_Result); end
        tick();
        vec_cnt++; if (Out_Valid !== 1'b0) begin err_cnt++; $display("FAIL rstmid_push_dropped got %b exp 0", Out_Valid); end
        drive_push(1'b1, 8'h77, 4'b0000, 4'b0000);
        tick();
        drive_push(1'b0, 8'h00, 4'b0000, 4'b0000);
        vec_cnt++; if (Out_Result !== 8'h77) begin err_cnt++; $display("FAIL rstmid_after got %h exp 77", Out_Result); end
    endtask

    initial begin
`ifdef CJB_SR_LOAD_EN
        SR_Load = 1'b0;
        SR_Data = 4'b0000;
`endif
        test_reset();
        test_push_basic();
        test_full();
        test_flag_mask();
        test_back_to_back();
`ifdef CJB_SR_LOAD_EN
        test_sr_load();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
